mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  CPU-side initiator for the data-memory/MMIO port: accepts one load/store
//  request per handshake from the execute stage and drives MemRead, MemWrite,
//  addr, din, length and sign into the data memory.
//  Handles misalignment checks, read-latency waiting and result return.
//  One access is in flight at a time; the block stalls the pipeline through req_ready.
// PARAMETERS
//  READ_LATENCY  2   posedges after the ACCESS edge until mem_dout is valid (legal range 1..7)
//  IO_BIT        31  address bit selecting the MMIO region (1 = IO; no alignment check)
// PORTS
//  clk              in   1   system clock; all state updates on posedge
//  rst              in   1   synchronous, active-high reset
//  req_valid        in   1   request present
//  req_ready        out  1   block can accept a request (IDLE only)
//  req_store        in   1   1 = store, 0 = load
//  req_length       in   2   0 = byte, 1 = half, 2 = word; 3 is treated as word
//  req_sign         in   1   load sign-extension select (1 = signed)
//  req_addr         in   32  byte address
//  req_wdata        in   32  store data
//  resp_valid       out  1   response available
//  resp_ready       in   1   consumer takes the response
//  resp_rdata       out  32  load data (0 for stores and misaligned accesses)
//  resp_misaligned  out  1   access rejected for alignment
//  MemRead          out  1   memory read strobe
//  MemWrite         out  1   memory write strobe
//  mem_addr         out  32  memory address
//  mem_din          out  32  memory write data
//  mem_length       out  2   memory access size
//  mem_sign         out  1   memory sign-extension select
//  mem_dout         in   32  memory read data (already extended by the memory)
// BEHAVIOUR
//  Reset: state = IDLE, wait counter = 0; every output = 0 except req_ready = 1.
//   rst wins over all other inputs on the same edge, including mid-access:
//   MemWrite/MemRead drop at that edge and any pending response is discarded.
//  FSM states: IDLE, ACCESS, WAIT, RESP.
//  IDLE: req_ready = 1. On req_valid, latch store/length/sign/addr/wdata.
//   Misaligned = addr[IO_BIT]==0 and ((length==1 && addr[0]) or (length>=2 && addr[1:0]!=0)).
//   Misaligned -> RESP with resp_misaligned = 1, resp_rdata = 0; no memory strobe.
//   Aligned -> ACCESS.
//  ACCESS (exactly one cycle): mem_* driven from the latched request.
//   Store: MemWrite = 1 for this cycle only, then -> RESP.
//   Load: MemRead = 1, counter loaded with READ_LATENCY-1, then -> WAIT
//   (if READ_LATENCY = 1: capture mem_dout here and go -> RESP).
//  WAIT: MemRead stays 1 and mem_* stay stable; counter decrements by 1 per cycle.
//   When the counter reaches 1, capture mem_dout into resp_rdata and go -> RESP.
//  mem_addr, mem_din, mem_length and mem_sign hold the last request's values
//   outside ACCESS/WAIT; MemRead and MemWrite are 0 outside ACCESS/WAIT.
//  RESP: resp_valid = 1; resp_rdata and resp_misaligned are held stable until
//   resp_ready is sampled high, then -> IDLE (resp_valid = 0 the next cycle).
//  Latencies (request edge to resp_valid rising):
//   load = READ_LATENCY+1 cycles; store = 2 cycles; misaligned = 1 cycle.
//  req_valid outside IDLE is ignored; there is no overlap and no request queue.
//  Stores return resp_rdata = 0 and resp_misaligned = 0.
//  A write to an IO address (e.g. LED) is issued the same way as a RAM store;
//   the memory performs the decode.
// TESTING
//  1. Word load at 0x10, memory returns 0xDEADBEEF:
//     -> MemRead high for 2 cycles, resp_valid 3 cycles after the request, rdata = 0xDEADBEEF.
//  2. Byte store of 0xA5 to 0x07:
//     -> MemWrite high exactly 1 cycle with mem_din = 0xA5, mem_length = 0, resp_valid 2 cycles later.
//  3. Half load at 0x03:
//     -> no MemRead/MemWrite, resp_valid next cycle with resp_misaligned = 1, rdata = 0.
//  4. Word load at 0x80000002 (IO region):
//     -> no misalignment, normal load timing.
//  5. Hold resp_ready = 0 for 5 cycles while req_valid = 1:
//     -> resp_valid and rdata stay stable, req_ready = 0, no new access issued.
//  6. Assert rst during the WAIT of a load:
//     -> next cycle MemRead = 0, resp_valid = 0, req_ready = 1, no response produced.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store initiator for the data-memory/MMIO port: one access in flight,
// alignment rejection, fixed read-latency wait and held response.
module mem_access_ctrl #(
    parameter int READ_LATENCY = 2,
    parameter int IO_BIT       = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_length,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_length,
    output logic        mem_sign,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        store_q, store_d;
    logic [1:0]  len_q, len_d;
    logic        sign_q, sign_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        mis_q, mis_d;
    logic        req_mis;

    // IO-region addresses bypass the alignment check; length 3 behaves as word.
    always_comb begin
        req_mis = 1'b0;
        if (!req_addr[IO_BIT]) begin
            if (req_length == 2'd1)
                req_mis = req_addr[0];
            else if (req_length[1])
                req_mis = (req_addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            store_q <= 1'b0;
            len_q   <= '0;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            len_q   <= len_d;
            sign_q  <= sign_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        store_d = store_q;
        len_d   = len_q;
        sign_d  = sign_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    len_d   = req_length;
                    sign_d  = req_sign;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    mis_d   = req_mis;
                    state_d = req_mis ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (store_q) begin
                    state_d = RESP;
                end else if (READ_LATENCY <= 1) begin
                    rdata_d = mem_dout;
                    state_d = RESP;
                end else begin
                    cnt_d   = 3'(READ_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    rdata_d = mem_dout;
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    assign MemRead         = ((state_q == ACCESS) && !store_q) || (state_q == WAIT);
    assign MemWrite        = (state_q == ACCESS) && store_q;
    assign mem_addr        = addr_q;
    assign mem_din         = wdata_q;
    assign mem_length      = len_q;
    assign mem_sign        = sign_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized transaction-level bench for mem_access_ctrl against a
// cycle-count / alignment reference model.
module tb_mem_access_ctrl;

    localparam int RL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store, req_sign;
    logic [1:0]  req_length;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_misaligned;
    logic [31:0] resp_rdata;
    logic        MemRead, MemWrite, mem_sign;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [1:0]  mem_length;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.READ_LATENCY(RL), .IO_BIT(31)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_length(req_length), .req_sign(req_sign), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
        .MemRead(MemRead), .MemWrite(MemWrite), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_length(mem_length), .mem_sign(mem_sign),
        .mem_dout(mem_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_mis(input logic [31:0] a, input logic [1:0] len);
        int unsigned size;
        if (a >= 32'h8000_0000) return 1'b0;
        size = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        return (a % size) != 0;
    endfunction

    task automatic scramble_req();
        req_valid  = 1'($urandom_range(0, 1));
        req_store  = 1'($urandom_range(0, 1));
        req_length = 2'($urandom_range(0, 3));
        req_sign   = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    // Issues one request and follows it until the response is consumed.
    task automatic txn(input bit st, input logic [1:0] len, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input int hold);
        bit          mis;
        int          exp_lat, exp_rd_cyc, exp_wr_cyc, rd_cyc, wr_cyc, k;
        logic [31:0] dhist [0:31];
        logic [31:0] exp_rdata, rd0;
        logic        mis0;

        mis        = model_mis(a, len);
        exp_lat    = mis ? 1 : (st ? 2 : RL + 1);
        exp_rd_cyc = (mis || st) ? 0 : RL;
        exp_wr_cyc = (!mis && st) ? 1 : 0;
        chk("req_ready_idle", 32'(req_ready), 32'd1);

        req_valid = 1'b1; req_store = st; req_length = len; req_sign = sg;
        req_addr = a; req_wdata = wd; resp_ready = 1'b0;
        k = 0; rd_cyc = 0; wr_cyc = 0;
        do begin
            @(posedge clk); #1;
            k++;
            scramble_req();
            mem_dout = $urandom;
            dhist[k] = mem_dout;
            @(negedge clk);
            if (MemRead) begin
                rd_cyc++;
                chk("rd_addr", mem_addr, a);
                chk("rd_len", 32'(mem_length), 32'(len));
                chk("rd_sign", 32'(mem_sign), 32'(sg));
            end
            if (MemWrite) begin
                wr_cyc++;
                chk("wr_addr", mem_addr, a);
                chk("wr_din", mem_din, wd);
                chk("wr_len", 32'(mem_length), 32'(len));
            end
        end while (!resp_valid && k < 20);

        chk("latency", 32'(k), 32'(exp_lat));
        chk("memread_cycles", 32'(rd_cyc), 32'(exp_rd_cyc));
        chk("memwrite_cycles", 32'(wr_cyc), 32'(exp_wr_cyc));
        exp_rdata = (!mis && !st && exp_lat < 20) ? dhist[RL] : 32'd0;
        chk("rdata", resp_rdata, exp_rdata);
        chk("misaligned", 32'(resp_misaligned), 32'(mis));
        rd0 = resp_rdata; mis0 = resp_misaligned;

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            scramble_req();
            mem_dout = $urandom;
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, rd0);
            chk("hold_mis", 32'(resp_misaligned), 32'(mis0));
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_strobes", 32'({MemRead, MemWrite}), 32'd0);
        end

        resp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("done_valid", 32'(resp_valid), 32'd0);
        chk("done_ready", 32'(req_ready), 32'd1);
        chk("done_addr_held", mem_addr, a);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_length = 2'd0;
        req_sign = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        mem_dout = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_strobes", 32'({MemRead, MemWrite}), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        txn(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0);
        txn(1'b1, 2'd0, 1'b0, 32'h0000_0007, 32'h0000_00A5, 0);
        txn(1'b0, 2'd1, 1'b1, 32'h0000_0003, 32'h0, 0);
        txn(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 0);
        txn(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0, 5);
        txn(1'b1, 2'd3, 1'b0, 32'h0000_0022, 32'h1234_5678, 1);
        txn(1'b1, 2'd1, 1'b0, 32'h0000_0041, 32'h1, 0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = {1'($urandom_range(0, 1)), 25'd0, 6'($urandom)};
            txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
        end

        // Reset during the WAIT phase of a load.
        req_valid = 1'b1; req_store = 1'b0; req_length = 2'd2; req_addr = 32'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_memread", 32'(MemRead), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_memread", 32'(MemRead), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_resp", 32'({resp_valid, MemRead, MemWrite}), 32'd0);
        end
        resp_ready = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
